// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue and credit-limited imem requests.
// Define IF_PERF_CNT_EN to add the perf_fetch/perf_flush event counters.
module if_prefetch_unit #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_OUTST  = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_pc,
  input  logic        hold_if,
  input  logic        br,
  input  logic [31:0] pc_branch,
  input  logic        except,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_flush,
`endif
  output logic        inst_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTST);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      ret_pc_q, ret_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic [31:0]      inst_out_q, inst_out_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      q_pc_q [DEPTH];
  logic [31:0]      q_pc_d [DEPTH];
  logic [31:0]      q_inst_q [DEPTH];
  logic [31:0]      q_inst_d [DEPTH];
`ifdef IF_PERF_CNT_EN
  logic [31:0]      perf_fetch_q, perf_fetch_d;
  logic [31:0]      perf_flush_q, perf_flush_d;
`endif

  logic             redirect;
  logic [31:0]      target;
  logic [CNT_W:0]   credit_sum;
  logic             credit_ok;
  logic             acc;
  logic             rv;
  logic             push;
  logic             queue_empty;
  logic             bypass;
  logic             pop;
  logic             wr;

  assign redirect    = br || except;
  assign target      = except ? EXC_VECTOR : pc_branch;
  assign credit_sum  = {1'b0, count_q} + {1'b0, outst_q};
  assign credit_ok   = (credit_sum < DEPTH_C) && (outst_q < MAX_C);
  assign imem_req    = !rst && !hold_pc && credit_ok && !redirect;
  assign imem_addr   = fetch_pc_q;
  assign acc         = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv          = imem_rvalid && (outst_q != '0);
  assign push        = rv && (drop_q == '0);
  assign queue_empty = (count_q == '0);
  assign bypass      = push && queue_empty && !hold_if;
  assign pop         = !hold_if && !queue_empty;
  assign wr          = push && !bypass;

  assign pc_out      = pc_out_q;
  assign inst_out    = inst_out_q;
  assign inst_valid  = inst_valid_q;
`ifdef IF_PERF_CNT_EN
  assign perf_fetch  = perf_fetch_q;
  assign perf_flush  = perf_flush_q;
`endif

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    ret_pc_d     = ret_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_d       = drop_q;
    pc_out_d     = pc_out_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = inst_valid_q;
    q_pc_d       = q_pc_q;
    q_inst_d     = q_inst_q;
`ifdef IF_PERF_CNT_EN
    perf_fetch_d = perf_fetch_q + 32'(push);
    perf_flush_d = perf_flush_q + 32'(redirect);
`endif

    outst_d = outst_q + CNT_W'(acc) - CNT_W'(rv);

    if (acc) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rv && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    if (push) ret_pc_d = ret_pc_q + 32'd4;

    if (wr) begin
      q_pc_d[wr_ptr_q]   = ret_pc_q;
      q_inst_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr) - CNT_W'(pop);

    // An empty queue forwards the returning word straight to ID to save a cycle.
    if (!hold_if) begin
      if (pop) begin
        pc_out_d     = q_pc_q[rd_ptr_q] + 32'd4;
        inst_out_d   = q_inst_q[rd_ptr_q];
        inst_valid_d = 1'b1;
      end else if (bypass) begin
        pc_out_d     = ret_pc_q + 32'd4;
        inst_out_d   = imem_rdata;
        inst_valid_d = 1'b1;
      end else begin
        inst_out_d   = 32'd0;
        inst_valid_d = 1'b0;
      end
    end

    // Everything still in flight belongs to the old stream and must be discarded.
    if (redirect) begin
      fetch_pc_d   = target;
      ret_pc_d     = target;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      drop_d       = outst_d;
      inst_out_d   = 32'd0;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      ret_pc_q     <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      pc_out_q     <= 32'd0;
      inst_out_q   <= 32'd0;
      inst_valid_q <= 1'b0;
`ifdef IF_PERF_CNT_EN
      perf_fetch_q <= 32'd0;
      perf_flush_q <= 32'd0;
`endif
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      ret_pc_q     <= ret_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
`ifdef IF_PERF_CNT_EN
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    q_pc_q   <= q_pc_d;
    q_inst_q <= q_inst_d;
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed testbench for if_prefetch_unit with a simple in-order imem responder.
// Perf counter checks are included when IF_PERF_CNT_EN is defined.
module tb_if_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        hold_pc;
  logic        hold_if;
  logic        br;
  logic [31:0] pc_branch;
  logic        except;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  int          tests_run;
  int          tests_failed;
  logic        mem_hold;
  logic [31:0] pend [$];

  if_prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .hold_pc     (hold_pc),
    .hold_if     (hold_if),
    .br          (br),
    .pc_branch   (pc_branch),
    .except      (except),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
`ifdef IF_PERF_CNT_EN
    .perf_fetch  (perf_fetch),
    .perf_flush  (perf_flush),
`endif
    .inst_valid  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance n cycles; the imem returns each granted request one cycle later unless mem_hold is set.
  task automatic applyStimulus(input int n);
    logic        hs;
    logic [31:0] hs_addr;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      hs      = imem_req && imem_gnt;
      hs_addr = imem_addr;
      @(posedge clk);
      #1;
      if (rst) pend.delete();
      else if (hs) pend.push_back(hs_addr);
      if (!mem_hold && !rst && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    hold_pc      = 1'b0;
    hold_if      = 1'b0;
    br           = 1'b0;
    except       = 1'b0;
    pc_branch    = 32'd0;
    imem_gnt     = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;
    mem_hold     = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOutput("rst_req",   32'(imem_req),   32'd0);
    checkOutput("rst_addr",  imem_addr,       32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_pc",    pc_out,          32'd0);
    checkOutput("rst_inst",  inst_out,        32'd0);

    // Streaming fetch, one-cycle imem
    rst = 1'b0;
    #1;
    checkOutput("t1_req0",  32'(imem_req), 32'd1);
    checkOutput("t1_addr0", imem_addr,     32'd0);
    applyStimulus(1);
    checkOutput("t1_bubble", 32'(inst_valid), 32'd0);
    checkOutput("t1_addr1",  imem_addr,       32'd4);
    applyStimulus(1);
    checkOutput("t1_valid1", 32'(inst_valid), 32'd1);
    checkOutput("t1_pc1",    pc_out,          32'd4);
    checkOutput("t1_inst1",  inst_out,        inst_of(32'd0));
    applyStimulus(1);
    checkOutput("t1_pc2",    pc_out,          32'd8);
    checkOutput("t1_addr3",  imem_addr,       32'd12);
    applyStimulus(1);
    checkOutput("t1_pc3",    pc_out,          32'd12);

    // ID stall: outputs freeze while the queue fills
    hold_if = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput("t2_frz_pc",    pc_out,          32'd12);
      checkOutput("t2_frz_inst",  inst_out,        inst_of(32'd8));
      checkOutput("t2_frz_valid", 32'(inst_valid), 32'd1);
      if (i >= 3) checkOutput("t2_full_req", 32'(imem_req), 32'd0);
    end
    hold_if = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput("t2_drain_valid", 32'(inst_valid), 32'd1);
      checkOutput("t2_drain_pc",    pc_out,          32'd16 + 32'(4 * i));
      checkOutput("t2_drain_inst",  inst_out,        inst_of(32'd12 + 32'(4 * i)));
    end

    // Grant withheld: address stable, queue drains to a bubble
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("t5_addr_stable", imem_addr, 32'd48);
      checkOutput("t5_pc",          pc_out,    32'd40 + 32'(4 * i));
    end
    checkOutput("t5_req_held", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    applyStimulus(1);
    checkOutput("t5_bubble_valid", 32'(inst_valid), 32'd0);
    checkOutput("t5_bubble_inst",  inst_out,        32'd0);
    applyStimulus(1);
    checkOutput("t5_resume_valid", 32'(inst_valid), 32'd1);
    checkOutput("t5_resume_pc",    pc_out,          32'd52);

    // Branch with two requests in flight
    mem_hold = 1'b1;
    applyStimulus(2);
    checkOutput("t3_outst_req", 32'(imem_req), 32'd0);
    br        = 1'b1;
    pc_branch = 32'h0000_0100;
    applyStimulus(1);
    checkOutput("t3_br_valid", 32'(inst_valid), 32'd0);
    checkOutput("t3_br_addr",  imem_addr,       32'h0000_0100);
`ifdef IF_PERF_CNT_EN
    checkOutput("t3_perf_flush", perf_flush, 32'd1);
`endif
    br       = 1'b0;
    mem_hold = 1'b0;
    applyStimulus(2);
    checkOutput("t3_drop_valid", 32'(inst_valid), 32'd0);
    checkOutput("t3_tgt_req",    32'(imem_req),   32'd1);
    checkOutput("t3_tgt_addr",   imem_addr,       32'h0000_0100);
    applyStimulus(1);
    checkOutput("t3_drop2_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t3_new_valid", 32'(inst_valid), 32'd1);
    checkOutput("t3_new_pc",    pc_out,          32'h0000_0104);
    checkOutput("t3_new_inst",  inst_out,        inst_of(32'h0000_0100));

    // Exception and branch together
    except    = 1'b1;
    br        = 1'b1;
    pc_branch = 32'h0000_0200;
    #1;
    checkOutput("t4_redir_req", 32'(imem_req), 32'd0);
    applyStimulus(1);
    except = 1'b0;
    br     = 1'b0;
    #1;
    checkOutput("t4_exc_addr",  imem_addr,       32'h8000_0180);
    checkOutput("t4_exc_req",   32'(imem_req),   32'd1);
    checkOutput("t4_exc_valid", 32'(inst_valid), 32'd0);
    applyStimulus(2);
    checkOutput("t4_vec_valid", 32'(inst_valid), 32'd1);
    checkOutput("t4_vec_pc",    pc_out,          32'h8000_0184);
    checkOutput("t4_vec_inst",  inst_out,        inst_of(32'h8000_0180));
`ifdef IF_PERF_CNT_EN
    checkOutput("t4_perf_flush", perf_flush, 32'd2);
`endif

    // Reset with a full queue
    hold_if = 1'b1;
    applyStimulus(5);
    checkOutput("t6_full_req", 32'(imem_req), 32'd0);
    checkOutput("t6_frz_pc",   pc_out,        32'h8000_0184);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("t6_rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("t6_rst_inst",  inst_out,        32'd0);
    checkOutput("t6_rst_pc",    pc_out,          32'd0);
    checkOutput("t6_rst_addr",  imem_addr,       32'd0);
    checkOutput("t6_rst_req",   32'(imem_req),   32'd0);
`ifdef IF_PERF_CNT_EN
    checkOutput("t6_perf_fetch", perf_fetch, 32'd0);
    checkOutput("t6_perf_flush", perf_flush, 32'd0);
`endif
    rst     = 1'b0;
    hold_if = 1'b0;
    #1;
    checkOutput("t6_post_req",  32'(imem_req), 32'd1);
    checkOutput("t6_post_addr", imem_addr,     32'd0);
    applyStimulus(2);
    checkOutput("t6_post_valid", 32'(inst_valid), 32'd1);
    checkOutput("t6_post_pc",    pc_out,          32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
